seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Shares one BCD-to-seven-segment decoder instance across all digits.
- Holds a double-buffered digit register loaded through a ready/load handshake.
- Sits between the numeric datapath (counters, calculators) and the board display pins.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/BCD_to_sevenSeg.sv | 40 ++++
 rtl/seven_seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg : shared types, constants and anode helper for the scan ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  // One-hot-cold (active-low) anode vector for a digit index
  function automatic logic [MAX_DIGITS-1:0] anode_sel(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/BCD_to_sevenSeg.sv
// ============================================================================
// BCD_to_sevenSeg : combinational hex-to-seven-segment decoder, active-low
// Rev 1.0
// ============================================================================
`default_nettype none

module BCD_to_sevenSeg
  import seven_seg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Pattern order is {g,f,e,d,c,b,a}, a lit segment drives 0
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// seven_seg_scan_ctrl : N-digit multiplexed seven-segment scanner with a
// double-buffered digit register. Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  ready,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segments,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_active_buf;
  logic [4*N_DIGITS-1:0] r_pending_buf;
  logic                  r_pending_flag;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_accept;
  bcd_t                  w_digit;
  seg_t                  w_dec_seg;
  seg_t                  w_seg_next;
  logic                  w_lz_blank;
  logic [MAX_DIGITS-1:0] w_anode_full;
  logic [N_DIGITS-1:0]   w_anode_next;
  logic                  w_unused_anode;

  assign w_tick   = enable && (r_div_cnt == LAST_CNT);
  assign w_wrap   = w_tick && (r_idx == LAST_IDX);
  assign w_accept = load && !r_pending_flag;
  assign ready    = !r_pending_flag;

  assign w_digit        = r_active_buf[{r_idx, 2'b00} +: 4];
  assign w_anode_full   = anode_sel(3'(r_idx));
  assign w_anode_next   = w_anode_full[N_DIGITS-1:0];
  assign w_unused_anode = &w_anode_full;

  BCD_to_sevenSeg u_dec (
    .bcd (w_digit),
    .seg (w_dec_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz_mask;

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    w_lz_mask = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero && (r_active_buf[4*i +: 4] == 4'd0);
      w_lz_mask[i] = all_zero;
    end
  end

  assign w_lz_blank = w_lz_mask[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_seg_next = ((w_digit > 4'd9) || w_lz_blank) ? SEG_BLANK : w_dec_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt      <= '0;
      r_idx          <= '0;
      r_active_buf   <= '0;
      r_pending_buf  <= '0;
      r_pending_flag <= 1'b0;
      anodes         <= '1;
      segments       <= SEG_BLANK;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= w_wrap;

      if (enable) begin
        anodes   <= w_anode_next;
        segments <= w_seg_next;
        if (w_tick) begin
          r_div_cnt <= '0;
          r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end else begin
        anodes   <= '1;
        segments <= SEG_BLANK;
      end

      // Commit only at the frame boundary so a frame never mixes two values
      if (w_wrap && r_pending_flag) begin
        r_active_buf   <= r_pending_buf;
        r_pending_flag <= 1'b0;
      end else if (w_accept) begin
        r_pending_buf  <= bcd_in;
        r_pending_flag <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// tb_seven_seg_scan_ctrl : scoreboard bench for seven_seg_scan_ctrl (N=4, DIV=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        ready;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .ready      (ready),
    .anodes     (anodes),
    .segments   (segments),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: scan position within a frame in enabled clocks
  int          m_pos;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_flag;

  int errors = 0;
  int checks = 0;

  // Active-high lit-segment sets (bit0 = a ... bit6 = g)
  function automatic logic [6:0] lit(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] expected_seg(input logic [15:0] digits, input int d);
    logic [3:0] v;
    int msd;
    msd = 0;
    for (int k = 0; k < N; k++)
      if (digits[k*4 +: 4] != 4'd0) msd = k;
    v = digits[d*4 +: 4];
    if (v > 4'd9) return 7'h7F;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (d > msd) return 7'h7F;
`endif
    return ~lit(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: predicts what each edge leaves on the outputs
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pos = 0; m_active = '0; m_pending = '0; m_flag = 0;
        e.an = 4'hF; e.seg = 7'h7F; e.fd = 1'b0; e.rdy = 1'b1;
      end else begin
        if (enable) begin
          d     = m_pos / DIV;
          e.an  = ~(4'b0001 << d);
          e.seg = expected_seg(m_active, d);
        end else begin
          e.an  = 4'hF;
          e.seg = 7'h7F;
        end
        e.fd = enable && (m_pos == FRAME - 1);
        if (enable) m_pos = (m_pos + 1) % FRAME;
        if (e.fd && m_flag) begin
          m_active = m_pending;
          m_flag   = 0;
        end else if (load && !m_flag) begin
          m_pending = bcd_in;
          m_flag    = 1;
        end
        e.rdy = !m_flag;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compares every presented output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("anodes",     16'(anodes),     16'(e.an));
        check("segments",   16'(segments),   16'(e.seg));
        check("frame_done", 16'(frame_done), 16'(e.fd));
        check("ready",      16'(ready),      16'(e.rdy));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 4 * FRAME && m_pos != p; i++) step();
    checks++;
    if (m_pos != p) begin
      errors++;
      $display("FAIL wait_pos: position %0d, expected %0d", m_pos, p);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (40) step();

    drive_load(16'h1234);
    drive_load(16'h9999);
    repeat (40) step();

    wait_pos(FRAME - 1);
    drive_load(16'h5678);
    repeat (40) step();

    wait_pos(2 * DIV + 1);
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (30) step();

    drive_load(16'h3C21);
    repeat (40) step();
    drive_load(16'h0070);
    repeat (40) step();
    drive_load(16'h0000);
    repeat (40) step();

    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 3) == 0);
      bcd_in = 16'($urandom);
      reset  = ($urandom_range(0, 149) == 0);
      step();
    end
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b1;
    repeat (20) step();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
